pdm_cic_integrator: RTL

- Front end of the per-microphone PDM-to-PCM CIC decimator.
- Generates the PDM microphone clock and samples the 1-bit PDM stream.
- Runs three cascaded integrators at the PDM rate and decimates by DECIM.
- Emits the decimated 19-bit integrator sample plus the lr_clk frame clock consumed by the downstream third-order comb/differentiator stage.

---
 rtl/pdm_cic_integrator_pkg.sv | 10 +
 rtl/pdm_cic_integrator_if.sv | 37 +++
 rtl/pdm_cic_integrator_clk_gen.sv | 41 ++++
 rtl/pdm_cic_integrator.sv | 116 +++++++++++
 4 files changed

// File: rtl/pdm_cic_integrator_pkg.sv
// Shared CIC constants and sample type for the PDM decimator integrator and comb stages.
package cic_pkg;

  localparam int CIC_WIDTH  = 19;
  localparam int CIC_DECIM  = 64;
  localparam int CIC_STAGES = 3;

  typedef logic signed [CIC_WIDTH-1:0] cic_sample_t;

endpackage

// File: rtl/pdm_cic_integrator_if.sv
// Microphone / decimated-sample bus of the CIC integrator front end.
// PDM_STEREO_EN adds the right-channel sample out_r.
interface pdm_cic_integrator_if #(
  parameter int WIDTH = cic_pkg::CIC_WIDTH
);

  logic                    en;
  logic                    pdm_data;
  logic                    pdm_clk;
  logic                    lr_clk;
  logic signed [WIDTH-1:0] out;
  logic                    out_valid;
`ifdef PDM_STEREO_EN
  logic signed [WIDTH-1:0] out_r;

  modport master (
    output en, pdm_data,
    input  pdm_clk, lr_clk, out, out_valid, out_r
  );

  modport slave (
    input  en, pdm_data,
    output pdm_clk, lr_clk, out, out_valid, out_r
  );
`else
  modport master (
    output en, pdm_data,
    input  pdm_clk, lr_clk, out, out_valid
  );

  modport slave (
    input  en, pdm_data,
    output pdm_clk, lr_clk, out, out_valid
  );
`endif

endinterface

// File: rtl/pdm_cic_integrator_clk_gen.sv
// PDM microphone clock divider; flags the clk cycle in which pdm_clk is about to rise or fall.
module pdm_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic pdm_clk,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          wrap;

  assign wrap = en && (div_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      pdm_clk <= ~pdm_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Events are valid in the cycle whose closing edge registers the pdm_clk transition.
  always_comb begin
    rise_evt = wrap && !pdm_clk;
    fall_evt = wrap &&  pdm_clk;
  end

endmodule

// File: rtl/pdm_cic_integrator.sv
// CIC decimator front end: PDM clocking, three cascaded integrators, decimation by DECIM.
// Define PDM_STEREO_EN for a second (rising-edge) integrator chain driving out_r.
module pdm_cic_integrator
  import cic_pkg::*;
#(
  parameter int WIDTH   = CIC_WIDTH,
  parameter int DECIM   = CIC_DECIM,
  parameter int CLK_DIV = 2
) (
  input logic                 clk,
  input logic                 rst,
  pdm_cic_integrator_if.slave bus
);

`ifdef PDM_STEREO_EN
  localparam int NCH = 2;
`else
  localparam int NCH = 1;
`endif
  localparam int DW = $clog2(DECIM);

  typedef logic signed [WIDTH-1:0] acc_t;

  logic          fall_evt;
  logic [NCH-1:0] bit_in;
  acc_t          tap [NCH];
  logic [DW-1:0] dec_cnt;
  logic [DW-1:0] dec_nxt;
  logic          frame_end;

`ifdef PDM_STEREO_EN
  logic rise_evt;
  logic r_bit;
`else
  logic rise_evt_unused;
`endif

  pdm_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .pdm_clk  (bus.pdm_clk),
`ifdef PDM_STEREO_EN
    .rise_evt (rise_evt),
`else
    .rise_evt (rise_evt_unused),
`endif
    .fall_evt (fall_evt)
  );

`ifdef PDM_STEREO_EN
  // Right mic bit captured on the rising edge so both chains integrate in lockstep on fall_evt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_bit <= 1'b0;
    else if (rise_evt) r_bit <= bus.pdm_data;
  end
  assign bit_in = {r_bit, bus.pdm_data};
`else
  assign bit_in = bus.pdm_data;
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_chain
    acc_t x;
    acc_t acc [CIC_STAGES];
    acc_t sum [CIC_STAGES];

    // Each stage adds the freshly summed value of the stage before it; all adds wrap mod 2^WIDTH.
    always_comb begin
      x      = bit_in[c] ? acc_t'(1) : acc_t'(-1);
      sum[0] = acc[0] + x;
      for (int unsigned k = 1; k < CIC_STAGES; k++) begin
        sum[k] = acc[k] + sum[k-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned k = 0; k < CIC_STAGES; k++) acc[k] <= '0;
      end else if (fall_evt) begin
        for (int unsigned k = 0; k < CIC_STAGES; k++) acc[k] <= sum[k];
      end
    end

    assign tap[c] = acc[CIC_STAGES-1];
  end

  assign dec_nxt   = dec_cnt + 1'b1;
  assign frame_end = (dec_cnt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt       <= '0;
      bus.lr_clk    <= 1'b0;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
`ifdef PDM_STEREO_EN
      bus.out_r     <= '0;
`endif
    end else begin
      bus.out_valid <= fall_evt && frame_end;
      if (fall_evt) begin
        dec_cnt    <= dec_nxt;
        bus.lr_clk <= (dec_nxt < DW'(DECIM / 2));
        if (frame_end) begin
          bus.out   <= tap[0];
`ifdef PDM_STEREO_EN
          bus.out_r <= tap[1];
`endif
        end
      end
    end
  end

endmodule
